// File: rtl/cache_miss_ctrl_pkg.sv
// Shared widths, FSM state encoding and address field helpers for the cache miss controller.
package cache_pkg;

   localparam int TAG_W   = 26;
   localparam int INDEX_W = 3;
   localparam int HALT_W  = 4;
   localparam int DATA_W  = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      FILL,
      UPDATE,
      RESP
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return TAG_W'(addr >> (32 - TAG_W));
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      return INDEX_W'(addr >> 3);
   endfunction

   function automatic logic [HALT_W-1:0] halt_of(input logic [TAG_W-1:0] tag);
      return HALT_W'(tag);
   endfunction

   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [INDEX_W-1:0] idx);
      return {tag, idx, 3'b000};
   endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// CPU, storage-array and memory signals of the miss controller; master = controller side.
interface cache_miss_ctrl_if;
   import cache_pkg::*;

   logic              req_valid;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_hit;

   logic [INDEX_W-1:0] arr_index;
   logic [TAG_W-1:0]   arr_tag;
   logic               arr_valid;
   logic               arr_dirty;
   logic [DATA_W-1:0]  arr_data;
   logic               arr_we;
   logic [TAG_W-1:0]   arr_tag_wr;
   logic               arr_valid_wr;
   logic               arr_dirty_wr;
   logic [DATA_W-1:0]  arr_data_wr;
   logic               halt_we;
   logic [HALT_W-1:0]  halt_tag_wr;

   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_hit,
      input  arr_tag, arr_valid, arr_dirty, arr_data,
      output arr_index, arr_we, arr_tag_wr, arr_valid_wr, arr_dirty_wr, arr_data_wr,
      output halt_we, halt_tag_wr,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_hit,
      output arr_tag, arr_valid, arr_dirty, arr_data,
      input  arr_index, arr_we, arr_tag_wr, arr_valid_wr, arr_dirty_wr, arr_data_wr,
      input  halt_we, halt_tag_wr,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/cache_miss_ctrl.sv
// Direct-mapped cache controller: lookup, dirty write-back, refill, array update, response.
// Hit load 2 cycles, hit store 3, miss 4 + memory waits; one request in flight, req_ready only in IDLE.
module cache_miss_ctrl
   import cache_pkg::*;
(
   input logic              clk,
   input logic              reset,
   cache_miss_ctrl_if.master bus
);

   state_e             state_q, state_d;
   logic [TAG_W-1:0]   tag_q;
   logic [INDEX_W-1:0] index_q;
   logic               write_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [TAG_W-1:0]   victim_tag_q;
   logic [DATA_W-1:0]  victim_data_q;
   logic [DATA_W-1:0]  line_q;
   logic               hit_q;
   logic               lookup_hit;

   assign lookup_hit = bus.arr_valid && (bus.arr_tag == tag_q);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req_valid) state_d = LOOKUP;
         LOOKUP: begin
            if (lookup_hit)                        state_d = write_q ? UPDATE : RESP;
            else if (bus.arr_valid && bus.arr_dirty) state_d = WB;
            else                                   state_d = FILL;
         end
         WB:      if (bus.mem_ack) state_d = FILL;
         FILL:    if (bus.mem_ack) state_d = UPDATE;
         UPDATE:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // line_q holds hit data or fill data; hit_q clears once memory is touched.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q         <= '0;
         index_q       <= '0;
         write_q       <= 1'b0;
         wdata_q       <= '0;
         victim_tag_q  <= '0;
         victim_data_q <= '0;
         line_q        <= '0;
         hit_q         <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.req_valid) begin
            tag_q   <= addr_tag(bus.req_addr);
            index_q <= addr_index(bus.req_addr);
            write_q <= bus.req_write;
            wdata_q <= bus.req_wdata;
            line_q  <= '0;
            hit_q   <= 1'b1;
         end
         if (state_q == LOOKUP) begin
            if (lookup_hit) begin
               line_q <= bus.arr_data;
            end else begin
               hit_q         <= 1'b0;
               victim_tag_q  <= bus.arr_tag;
               victim_data_q <= bus.arr_data;
            end
         end
         if (state_q == FILL && bus.mem_ack) line_q <= bus.mem_rdata;
      end
   end

   // Strobes are gated by reset so a reset mid-transaction drops them in the same cycle.
   always_comb begin
      bus.req_ready    = (state_q == IDLE);
      bus.resp_valid   = 1'b0;
      bus.resp_rdata   = '0;
      bus.resp_hit     = 1'b0;
      bus.arr_index    = index_q;
      bus.arr_we       = 1'b0;
      bus.arr_tag_wr   = '0;
      bus.arr_valid_wr = 1'b0;
      bus.arr_dirty_wr = 1'b0;
      bus.arr_data_wr  = '0;
      bus.halt_we      = 1'b0;
      bus.halt_tag_wr  = '0;
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      if (!reset) begin
         unique case (state_q)
            WB: begin
               bus.mem_req   = 1'b1;
               bus.mem_we    = 1'b1;
               bus.mem_addr  = line_addr(victim_tag_q, index_q);
               bus.mem_wdata = victim_data_q;
            end
            FILL: begin
               bus.mem_req  = 1'b1;
               bus.mem_addr = line_addr(tag_q, index_q);
            end
            UPDATE: begin
               bus.arr_we       = 1'b1;
               bus.arr_tag_wr   = tag_q;
               bus.arr_valid_wr = 1'b1;
               bus.arr_dirty_wr = write_q;
               bus.arr_data_wr  = write_q ? wdata_q : line_q;
               bus.halt_we      = 1'b1;
               bus.halt_tag_wr  = halt_of(tag_q);
            end
            RESP: begin
               bus.resp_valid = 1'b1;
               bus.resp_rdata = write_q ? '0 : line_q;
               bus.resp_hit   = hit_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench: behavioural tag/data arrays and a delayed-ack memory around cache_miss_ctrl.
module tb_cache_miss_ctrl;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cache_miss_ctrl_if bus();
   cache_miss_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   logic [TAG_W-1:0]  tag_a   [8];
   logic              val_a   [8];
   logic              dirty_a [8];
   logic [DATA_W-1:0] data_a  [8];
   logic [HALT_W-1:0] halt_a  [8];
   logic              clr_arr = 1'b1;

   assign bus.arr_tag   = tag_a[bus.arr_index];
   assign bus.arr_valid = val_a[bus.arr_index];
   assign bus.arr_dirty = dirty_a[bus.arr_index];
   assign bus.arr_data  = data_a[bus.arr_index];

   int we_cnt = 0, halt_cnt = 0, mreq_cnt = 0, wb_cnt = 0, fill_cnt = 0, unst_cnt = 0;
   int s_we, s_halt, s_mreq, s_wb, s_fill, s_unst;
   logic [TAG_W-1:0]  wr_tag;
   logic              wr_dirty;
   logic [DATA_W-1:0] wr_data;
   logic [2:0]        wr_idx;
   logic [HALT_W-1:0] wr_halt;
   logic [31:0]       wb_addr, wb_data, fill_addr;
   int                ack_delay = 0, wait_cnt = 0;
   logic              hold = 1'b0;
   logic [31:0]       hold_addr, hold_wdata;
   logic              hold_we;
   int                n_checks = 0, n_fail = 0;

   // Arrays commit at negedge; memory acks after ack_delay extra cycles of mem_req.
   always @(negedge clk) begin
      if (clr_arr) begin
         for (int i = 0; i < 8; i++) begin
            tag_a[i] = '0; val_a[i] = 1'b0; dirty_a[i] = 1'b0; data_a[i] = '0; halt_a[i] = '0;
         end
      end
      if (bus.arr_we) begin
         tag_a[bus.arr_index]   = bus.arr_tag_wr;
         val_a[bus.arr_index]   = bus.arr_valid_wr;
         dirty_a[bus.arr_index] = bus.arr_dirty_wr;
         data_a[bus.arr_index]  = bus.arr_data_wr;
         we_cnt++; wr_tag = bus.arr_tag_wr; wr_dirty = bus.arr_dirty_wr;
         wr_data = bus.arr_data_wr; wr_idx = bus.arr_index;
      end
      if (bus.halt_we) begin
         halt_a[bus.arr_index] = bus.halt_tag_wr;
         halt_cnt++; wr_halt = bus.halt_tag_wr;
      end
      if (bus.mem_req) begin
         mreq_cnt++;
         if (hold && (bus.mem_addr !== hold_addr || bus.mem_we !== hold_we || bus.mem_wdata !== hold_wdata))
            unst_cnt++;
         if (bus.mem_we) begin wb_cnt++; wb_addr = bus.mem_addr; wb_data = bus.mem_wdata; end
         else begin fill_cnt++; fill_addr = bus.mem_addr; end
         if (wait_cnt >= ack_delay) begin
            bus.mem_ack = 1'b1; wait_cnt = 0; hold = 1'b0;
         end else begin
            bus.mem_ack = 1'b0; wait_cnt++; hold = 1'b1;
            hold_addr = bus.mem_addr; hold_we = bus.mem_we; hold_wdata = bus.mem_wdata;
         end
      end else begin
         bus.mem_ack = 1'b0; wait_cnt = 0; hold = 1'b0;
      end
   end

   task automatic snap();
      s_we = we_cnt; s_halt = halt_cnt; s_mreq = mreq_cnt;
      s_wb = wb_cnt; s_fill = fill_cnt; s_unst = unst_cnt;
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic hit);
      @(negedge clk);
      snap();
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = -1; rd = '1; hit = 1'bx;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk); #1;
         if (bus.resp_valid) begin
            lat = i; rd = bus.resp_rdata; hit = bus.resp_hit;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.mem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0b want 1", bus.req_ready); end
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0b want 0", bus.resp_valid); end
      n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem: got req=%0b we=%0b want 0 0", bus.mem_req, bus.mem_we); end
      n_checks++; if (bus.arr_we !== 1'b0 || bus.halt_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got arr_we=%0b halt_we=%0b want 0 0", bus.arr_we, bus.halt_we); end
      n_checks++; if (bus.arr_index !== 3'd0 || bus.mem_addr !== 32'd0 || bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_values: got idx=%0d addr=%h rdata=%h want 0 0 0", bus.arr_index, bus.mem_addr, bus.resp_rdata); end
      clr_arr = 1'b0;
      reset = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0b want 1", bus.req_ready); end
   endtask

   task automatic test_load_miss();
      int lat; logic [31:0] rd; logic hit;
      ack_delay = 0; bus.mem_rdata = 32'hDEADBEEF;
      issue(1'b0, 32'h0000_0040, 32'h0, lat, rd, hit);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL lmiss_latency: got %0d want 4", lat); end
      n_checks++; if (rd !== 32'hDEADBEEF || hit !== 1'b0) begin n_fail++; $display("FAIL lmiss_resp: got %h hit=%0b want deadbeef hit=0", rd, hit); end
      n_checks++; if (fill_cnt - s_fill !== 1 || fill_addr !== 32'h40 || wb_cnt - s_wb !== 0) begin n_fail++; $display("FAIL lmiss_mem: got fills=%0d addr=%h wbs=%0d want 1 40 0", fill_cnt - s_fill, fill_addr, wb_cnt - s_wb); end
      n_checks++; if (we_cnt - s_we !== 1 || wr_idx !== 3'd0 || wr_tag !== 26'd1 || wr_dirty !== 1'b0 || wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lmiss_update: got n=%0d idx=%0d tag=%h dirty=%0b data=%h want 1 0 1 0 deadbeef", we_cnt - s_we, wr_idx, wr_tag, wr_dirty, wr_data); end
      n_checks++; if (val_a[0] !== 1'b1 || halt_cnt - s_halt !== 1 || halt_a[0] !== 4'h1) begin n_fail++; $display("FAIL lmiss_halt: got valid=%0b n=%0d halt=%h want 1 1 1", val_a[0], halt_cnt - s_halt, halt_a[0]); end
   endtask

   task automatic test_load_hit();
      int lat; logic [31:0] rd; logic hit;
      issue(1'b0, 32'h0000_0040, 32'h0, lat, rd, hit);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lhit_latency: got %0d want 2", lat); end
      n_checks++; if (rd !== 32'hDEADBEEF || hit !== 1'b1) begin n_fail++; $display("FAIL lhit_resp: got %h hit=%0b want deadbeef hit=1", rd, hit); end
      n_checks++; if (mreq_cnt - s_mreq !== 0 || we_cnt - s_we !== 0) begin n_fail++; $display("FAIL lhit_side: got mem_req=%0d arr_we=%0d want 0 0", mreq_cnt - s_mreq, we_cnt - s_we); end
   endtask

   task automatic test_store_hit();
      int lat; logic [31:0] rd; logic hit;
      issue(1'b1, 32'h0000_0040, 32'h0000_1234, lat, rd, hit);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL shit_latency: got %0d want 3", lat); end
      n_checks++; if (rd !== 32'h0 || hit !== 1'b1) begin n_fail++; $display("FAIL shit_resp: got %h hit=%0b want 0 hit=1", rd, hit); end
      n_checks++; if (we_cnt - s_we !== 1 || wr_dirty !== 1'b1 || wr_data !== 32'h1234 || mreq_cnt - s_mreq !== 0) begin n_fail++; $display("FAIL shit_update: got n=%0d dirty=%0b data=%h mem=%0d want 1 1 1234 0", we_cnt - s_we, wr_dirty, wr_data, mreq_cnt - s_mreq); end
   endtask

   task automatic test_dirty_evict();
      int lat; logic [31:0] rd; logic hit;
      ack_delay = 0; bus.mem_rdata = 32'hCAFEF00D;
      issue(1'b0, 32'h0000_0080, 32'h0, lat, rd, hit);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL evict_latency: got %0d want 5", lat); end
      n_checks++; if (wb_cnt - s_wb !== 1 || wb_addr !== 32'h40 || wb_data !== 32'h1234) begin n_fail++; $display("FAIL evict_wb: got n=%0d addr=%h data=%h want 1 40 1234", wb_cnt - s_wb, wb_addr, wb_data); end
      n_checks++; if (fill_cnt - s_fill !== 1 || fill_addr !== 32'h80) begin n_fail++; $display("FAIL evict_fill: got n=%0d addr=%h want 1 80", fill_cnt - s_fill, fill_addr); end
      n_checks++; if (rd !== 32'hCAFEF00D || hit !== 1'b0) begin n_fail++; $display("FAIL evict_resp: got %h hit=%0b want cafef00d hit=0", rd, hit); end
      n_checks++; if (tag_a[0] !== 26'd2 || dirty_a[0] !== 1'b0 || data_a[0] !== 32'hCAFEF00D || halt_a[0] !== 4'h2) begin n_fail++; $display("FAIL evict_line: got tag=%h dirty=%0b data=%h halt=%h want 2 0 cafef00d 2", tag_a[0], dirty_a[0], data_a[0], halt_a[0]); end
   endtask

   task automatic test_fill_delay();
      int lat; logic [31:0] rd; logic hit;
      ack_delay = 5; bus.mem_rdata = 32'h0BADC0DE;
      issue(1'b0, 32'h0000_01C0, 32'h0, lat, rd, hit);
      n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL delay_latency: got %0d want 9", lat); end
      n_checks++; if (mreq_cnt - s_mreq !== 6 || unst_cnt - s_unst !== 0) begin n_fail++; $display("FAIL delay_hold: got req_cycles=%0d unstable=%0d want 6 0", mreq_cnt - s_mreq, unst_cnt - s_unst); end
      n_checks++; if (fill_addr !== 32'h1C0 || wb_cnt - s_wb !== 0) begin n_fail++; $display("FAIL delay_addr: got addr=%h wbs=%0d want 1c0 0", fill_addr, wb_cnt - s_wb); end
      n_checks++; if (we_cnt - s_we !== 1 || halt_cnt - s_halt !== 1 || wr_halt !== 4'h7) begin n_fail++; $display("FAIL delay_update: got we=%0d halt_we=%0d halt=%h want 1 1 7", we_cnt - s_we, halt_cnt - s_halt, wr_halt); end
      n_checks++; if (rd !== 32'h0BADC0DE || hit !== 1'b0) begin n_fail++; $display("FAIL delay_resp: got %h hit=%0b want 0badc0de hit=0", rd, hit); end
   endtask

   task automatic test_store_miss();
      int lat; logic [31:0] rd; logic hit;
      ack_delay = 1; bus.mem_rdata = 32'h1111_1111;
      issue(1'b1, 32'h0000_0048, 32'h0000_5555, lat, rd, hit);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL smiss_latency: got %0d want 5", lat); end
      n_checks++; if (rd !== 32'h0 || hit !== 1'b0) begin n_fail++; $display("FAIL smiss_resp: got %h hit=%0b want 0 hit=0", rd, hit); end
      n_checks++; if (mreq_cnt - s_mreq !== 2 || wr_idx !== 3'd1 || wr_dirty !== 1'b1 || wr_data !== 32'h5555 || wr_tag !== 26'd1) begin n_fail++; $display("FAIL smiss_update: got mem=%0d idx=%0d dirty=%0b data=%h tag=%h want 2 1 1 5555 1", mreq_cnt - s_mreq, wr_idx, wr_dirty, wr_data, wr_tag); end
   endtask

   task automatic test_reset_during_wb();
      int lat; logic [31:0] rd; logic hit; logic seen;
      ack_delay = 20;
      @(negedge clk);
      snap();
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0088; bus.req_wdata = '0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (bus.mem_req && bus.mem_we) begin seen = 1'b1; break; end
      end
      n_checks++; if (seen !== 1'b1 || bus.mem_addr !== 32'h48 || bus.mem_wdata !== 32'h5555) begin n_fail++; $display("FAIL rwb_enter: got seen=%0b addr=%h data=%h want 1 48 5555", seen, bus.mem_addr, bus.mem_wdata); end
      reset = 1'b1; #1;
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rwb_drop: got mem_req=%0b want 0", bus.mem_req); end
      @(posedge clk); #1;
      n_checks++; if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rwb_idle: got ready=%0b mem_req=%0b want 1 0", bus.req_ready, bus.mem_req); end
      @(negedge clk);
      reset = 1'b0; #1;
      n_checks++; if (we_cnt - s_we !== 0 || halt_cnt - s_halt !== 0 || dirty_a[1] !== 1'b1) begin n_fail++; $display("FAIL rwb_noupdate: got we=%0d halt_we=%0d dirty=%0b want 0 0 1", we_cnt - s_we, halt_cnt - s_halt, dirty_a[1]); end
      ack_delay = 0; bus.mem_rdata = 32'h600D_F00D;
      issue(1'b0, 32'h0000_0088, 32'h0, lat, rd, hit);
      n_checks++; if (lat !== 5 || rd !== 32'h600DF00D || hit !== 1'b0) begin n_fail++; $display("FAIL rwb_retry_resp: got lat=%0d rd=%h hit=%0b want 5 600df00d 0", lat, rd, hit); end
      n_checks++; if (wb_addr !== 32'h48 || wb_data !== 32'h5555 || fill_addr !== 32'h88 || we_cnt - s_we !== 1) begin n_fail++; $display("FAIL rwb_retry_mem: got wb=%h/%h fill=%h we=%0d want 48/5555 88 1", wb_addr, wb_data, fill_addr, we_cnt - s_we); end
      n_checks++; if (tag_a[1] !== 26'd2 || dirty_a[1] !== 1'b0 || halt_a[1] !== 4'h2) begin n_fail++; $display("FAIL rwb_retry_line: got tag=%h dirty=%0b halt=%h want 2 0 2", tag_a[1], dirty_a[1], halt_a[1]); end
   endtask

   initial begin
      test_reset();
      test_load_miss();
      test_load_hit();
      test_store_hit();
      test_dirty_evict();
      test_fill_delay();
      test_store_miss();
      test_reset_during_wb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
